// File: rtl/pc_sequencer.sv
// PC sequencer: resolves branch/jump outcome from EX, owns the fetch PC and drives IF/ID flush.
// Optional misaligned-target trap is enabled by defining MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VEC     = 'h100
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_STALL,
  input  logic            EX_VALID,
  input  logic            BRANCH,
  input  logic            JUMP,
  input  logic [2:0]      PC_SRC,
  input  logic [2:0]      BR_TYPE,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic [XLEN-1:0] IMM,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            FLUSH,
  output logic            TAKEN,
  output logic            MISALIGN,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSHING = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t          state;
  logic [2:0]      cnt;
  logic [XLEN-1:0] pending;

  logic            cond;
  logic            redirect;
  logic            is_jalr;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_val;
  logic            accept;

  always_comb begin
    cond = 1'b0;
    case (BR_TYPE)
      3'b000:  cond = (RS1 == RS2);
      3'b001:  cond = (RS1 != RS2);
      3'b010:  cond = ($signed(RS1) <  $signed(RS2));
      3'b011:  cond = ($signed(RS1) >= $signed(RS2));
      3'b100:  cond = (RS1 <  RS2);
      3'b101:  cond = (RS1 >= RS2);
      default: cond = 1'b0;
    endcase
  end

  assign redirect = EX_VALID & (JUMP | (BRANCH & cond));
  assign is_jalr  = JUMP & (PC_SRC == 3'd3);
  assign jalr_sum = RS1 + IMM;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (EX_PC + IMM);

  // In HOLD the oldest redirect wins, so the load comes from the latched target.
  assign load_src = (state == HOLD) ? pending : target;
  assign accept   = ~PC_STALL & ((state == HOLD) | redirect);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (load_src[1:0] != 2'b00);
  assign load_val   = misaligned ? TRAP_VEC : load_src;
  assign MISALIGN   = accept & misaligned;
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_VEC;
  assign load_val    = load_src;
  assign MISALIGN    = 1'b0;
`endif

  assign TAKEN     = accept;
  assign FLUSH     = (state == HOLD) | redirect | ((state == FLUSHING) & (cnt != 3'd0));
  assign PC_PLUS4  = PC + XLEN'(4);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      PC      <= RESET_VEC;
      cnt     <= 3'd0;
      pending <= '0;
    end else begin
      case (state)
        RUN, FLUSHING: begin
          if (redirect && !PC_STALL) begin
            PC    <= load_val;
            state <= FLUSHING;
            cnt   <= CNT_LOAD;
          end else if (redirect) begin
            pending <= target;
            state   <= HOLD;
            cnt     <= 3'd0;
          end else begin
            if (!PC_STALL) PC <= PC_PLUS4;
            // Flush window counts down whether or not fetch is stalled.
            if (state == FLUSHING) begin
              if (cnt == 3'd0) state <= RUN;
              else             cnt   <= cnt - 3'd1;
            end
          end
        end
        HOLD: begin
          if (!PC_STALL) begin
            PC    <= load_val;
            state <= FLUSHING;
            cnt   <= CNT_LOAD;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares; directed spec scenarios plus random traffic.
module tb_pc_sequencer;

  localparam int          XLEN = 32;
  localparam int          FC   = 2;
  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TV   = 32'h100;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS_ON = 1'b1;
`else
  localparam bit MIS_ON = 1'b0;
`endif

  logic        clk, rst, stall, ex_valid, branch, jump;
  logic [2:0]  pc_src, br_type;
  logic [31:0] ex_pc, rs1, rs2, imm;
  logic [31:0] pc, pc_plus4;
  logic        flush, taken, misalign;
  logic [1:0]  dbg_state;

  pc_sequencer #(.XLEN(XLEN), .RESET_VEC(RV), .FLUSH_CYCLES(FC), .TRAP_VEC(TV)) dut (
    .CLK(clk), .RST(rst), .PC_STALL(stall), .EX_VALID(ex_valid), .BRANCH(branch),
    .JUMP(jump), .PC_SRC(pc_src), .BR_TYPE(br_type), .EX_PC(ex_pc), .RS1(rs1),
    .RS2(rs2), .IMM(imm), .PC(pc), .PC_PLUS4(pc_plus4), .FLUSH(flush),
    .TAKEN(taken), .MISALIGN(misalign), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2*XLEN+2:0] exp_q[$];

  // Reference model state.
  logic [31:0] m_pc   = RV;
  logic [31:0] m_pend = '0;
  bit          m_hold = 1'b0;
  int          m_left = 0;
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit br_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b010:  return $signed(a) <  $signed(b);
      3'b011:  return $signed(a) >= $signed(b);
      3'b100:  return a <  b;
      3'b101:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic s, input logic v, input logic b, input logic j,
                      input logic [2:0] src, input logic [2:0] bt, input logic [31:0] epc,
                      input logic [31:0] a, input logic [31:0] c, input logic [31:0] im);
    bit          red, acc, fl, mis;
    logic [31:0] tgt, srcv, ld;
    @(posedge clk);
    #2;
    rst = r; stall = s; ex_valid = v; branch = b; jump = j;
    pc_src = src; br_type = bt; ex_pc = epc; rs1 = a; rs2 = c; imm = im;
    red = v && (j || (b && br_cond(bt, a, c)));
    tgt = (j && src == 3'd3) ? ((a + im) & 32'hFFFF_FFFE) : (epc + im);
    if (m_hold) begin
      fl = 1'b1; acc = !s; srcv = m_pend;
    end else begin
      acc = red && !s; fl = red || (m_left > 0); srcv = tgt;
    end
    mis = acc && MIS_ON && (srcv[1:0] != 2'b00);
    ld  = mis ? TV : srcv;
    if (m_known) exp_q.push_back({m_pc, m_pc + 32'd4, fl, acc, mis});
    if (r) begin
      m_pc = RV; m_pend = '0; m_hold = 1'b0; m_left = 0; m_known = 1'b1;
    end else if (acc) begin
      m_pc = ld; m_hold = 1'b0; m_left = FC - 1;
    end else if (m_hold) begin
      m_hold = 1'b1;
    end else if (red) begin
      m_hold = 1'b1; m_pend = tgt; m_left = 0;
    end else begin
      if (m_left > 0) m_left--;
      if (!s) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle(input logic s);
    step(1'b0, s, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    logic [2*XLEN+2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pc",       pc,                 e[2*XLEN+2:XLEN+3]);
      chk("sb_pc_plus4", pc_plus4,           e[XLEN+2:3]);
      chk("sb_flush",    {31'd0, flush},     {31'd0, e[2]});
      chk("sb_taken",    {31'd0, taken},     {31'd0, e[1]});
      chk("sb_misalign", {31'd0, misalign},  {31'd0, e[0]});
    end
  end

  initial begin
    logic [31:0] p;
    logic [31:0] r_imm;
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; branch = 1'b0; jump = 1'b0;
    pc_src = '0; br_type = '0; ex_pc = '0; rs1 = '0; rs2 = '0; imm = '0;

    // Reset held two cycles, then PC counts 0,4,8.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    idle(1'b0); #1 chk("run_pc0", pc, 32'h0);
    idle(1'b0); #1 chk("run_pc4", pc, 32'h4);
    idle(1'b0); #1 chk("run_pc8", pc, 32'h8);

    // BEQ taken backwards.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'b000, 32'h40, 32'd5, 32'd5, 32'hFFFF_FFF0);
    #1 chk("beq_taken", {31'd0, taken}, 32'd1);
    chk("beq_flush0", {31'd0, flush}, 32'd1);
    idle(1'b0); #1 chk("beq_pc", pc, 32'h30);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    chk("beq_taken_off", {31'd0, taken}, 32'd0);
    idle(1'b0); #1 chk("beq_flush_end", {31'd0, flush}, 32'd0);
    idle(1'b0);

    // Signed vs unsigned compare.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'b010, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h40);
    #1 chk("blt_taken", {31'd0, taken}, 32'd1);
    idle(1'b0); #1 chk("blt_pc", pc, 32'h540);
    idle(1'b0); idle(1'b0);
    p = m_pc;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'b100, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h40);
    #1 chk("bltu_taken", {31'd0, taken}, 32'd0);
    idle(1'b0); #1 chk("bltu_pc", pc, p + 32'd4);

    // JALR clears bit0; bit1 remains set.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 32'h700, 32'h1001, 32'h0, 32'd2);
    #1 chk("jalr_mis", {31'd0, misalign}, {31'd0, MIS_ON});
    idle(1'b0);
`ifdef MISALIGN_TRAP_EN
    #1 chk("jalr_pc", pc, 32'h100);
`else
    #1 chk("jalr_pc", pc, 32'h1002);
`endif
    idle(1'b0); idle(1'b0);

    // Stalled redirect held; a younger redirect during hold is ignored.
    p = m_pc;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 32'h70, 32'h0, 32'h0, 32'h10);
    #1 chk("hold_flush_a", {31'd0, flush}, 32'd1);
    chk("hold_taken_a", {31'd0, taken}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 32'h100, 32'h0, 32'h0, 32'h100);
    #1 chk("hold_pc_b", pc, p);
    chk("hold_flush_b", {31'd0, flush}, 32'd1);
    idle(1'b1);
    #1 chk("hold_pc_c", pc, p);
    chk("hold_taken_c", {31'd0, taken}, 32'd0);
    idle(1'b0);
    #1 chk("release_taken", {31'd0, taken}, 32'd1);
    idle(1'b0); #1 chk("release_pc", pc, 32'h80);
    idle(1'b0); idle(1'b0);

    // Wrapping JAL target, then reset while flushing.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20);
    idle(1'b0); #1 chk("wrap_pc", pc, 32'h10);
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(1'b0); #1 chk("rst_mid_pc", pc, RV);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_imm = ($urandom_range(0, 7) == 0) ? $urandom() : (32'($urandom_range(0, 63)) << 2) - 32'd128;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), {$urandom()} & 32'hFFFF_FFFC,
           ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3)), r_imm);
    end

    idle(1'b0);
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
